// File: rtl/regfile_mp_pkg.sv
// Shared constants and register indices for the Y86-style architectural register file.
package regfile_mp_pkg;

  localparam int RF_DATA_WID   = 64;
  localparam int RF_ADDR_WID   = 4;
  localparam int RF_NUM_OF_REG = 15;
  localparam int RF_CNT_WID    = 2;

  typedef enum logic [3:0] {
    rax_ = 4'h0, rcx_ = 4'h1, rdx_ = 4'h2, rbx_ = 4'h3,
    rsp_ = 4'h4, rbp_ = 4'h5, rsi_ = 4'h6, rdi_ = 4'h7,
    r8_  = 4'h8, r9_  = 4'h9, r10_ = 4'hA, r11_ = 4'hB,
    r12_ = 4'hC, r13_ = 4'hD, r14_ = 4'hE, RNONE = 4'hF
  } reg_idx_e;

  // Number of write ports retiring a result into one register this cycle.
  function automatic logic [1:0] wr_hits(input logic hit_e, input logic hit_m);
    return {1'b0, hit_e} + {1'b0, hit_m};
  endfunction

endpackage

// File: rtl/regfile_mp_rf_pending_cnt.sv
// Saturating up/down pending-write counter for one register; clamps at 0 and at max.
module rf_pending_cnt #(
  parameter int CNT_WID = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               inc,
  input  logic [1:0]         dec,
  output logic [CNT_WID-1:0] cnt,
  output logic               ovf
);

  localparam logic [CNT_WID:0] MAX = {1'b0, {CNT_WID{1'b1}}};

  logic [CNT_WID-1:0] cnt_q, cnt_d;
  logic [CNT_WID:0]   sum, dec_w, diff;

  always_comb begin
    dec_w = (CNT_WID+1)'(dec);
    sum   = {1'b0, cnt_q} + {{CNT_WID{1'b0}}, inc};
    diff  = sum - dec_w;
    ovf   = (cnt_q == MAX[CNT_WID-1:0]) && inc && (dec == 2'd0);
    // Retiring more writes than were issued is legal and simply clamps at zero.
    if (sum <= dec_w)   cnt_d = '0;
    else if (diff > MAX) cnt_d = MAX[CNT_WID-1:0];
    else                 cnt_d = diff[CNT_WID-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write (E/M) register file with optional write bypass and a
// per-register pending-write scoreboard for RAW hazard detection.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int                DATA_WID   = RF_DATA_WID,
  parameter int                ADDR_WID   = RF_ADDR_WID,
  parameter int                NUM_OF_REG = RF_NUM_OF_REG,
  parameter int                NUM_RD     = 2,
  parameter int                BYPASS     = 1,
  parameter int                SP_IDX     = int'(rsp_),
  parameter logic [DATA_WID-1:0] SP_INIT  = DATA_WID'(64),
  parameter int                CNT_WID    = RF_CNT_WID
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_RD*ADDR_WID-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WID-1:0]   rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         we_E,
  input  logic [ADDR_WID-1:0]          destE,
  input  logic [DATA_WID-1:0]          valE,
  input  logic                         we_M,
  input  logic [ADDR_WID-1:0]          destM,
  input  logic [DATA_WID-1:0]          valM,
  input  logic                         sb_set,
  input  logic [ADDR_WID-1:0]          sb_addr,
  output logic                         sb_err
);

  localparam logic [ADDR_WID:0] NREG = (ADDR_WID+1)'(NUM_OF_REG);

  logic [DATA_WID-1:0]   data_q [NUM_OF_REG];
  logic [DATA_WID-1:0]   data_d [NUM_OF_REG];
  logic [CNT_WID-1:0]    cnt_v  [NUM_OF_REG];
  logic [1:0]            dec_v  [NUM_OF_REG];
  logic [NUM_OF_REG-1:0] inc_v, ovf_v;
  logic                  we_e_vld, we_m_vld, sb_vld;
  logic                  sb_err_q, sb_err_d;

  assign we_e_vld = we_E   && ({1'b0, destE}   < NREG);
  assign we_m_vld = we_M   && ({1'b0, destM}   < NREG);
  assign sb_vld   = sb_set && ({1'b0, sb_addr} < NREG);

  // M is written last so it wins a same-register collision with E.
  always_comb begin
    data_d = data_q;
    if (we_e_vld) data_d[destE] = valE;
    if (we_m_vld) data_d[destM] = valM;
    sb_err_d = sb_err_q | (|ovf_v);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NUM_OF_REG; r++)
        data_q[r] <= (r == SP_IDX) ? SP_INIT : '0;
      sb_err_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

  for (genvar r = 0; r < NUM_OF_REG; r++) begin : g_sb
    assign inc_v[r] = sb_vld && (sb_addr == ADDR_WID'(r));
    assign dec_v[r] = wr_hits(we_e_vld && (destE == ADDR_WID'(r)),
                              we_m_vld && (destM == ADDR_WID'(r)));
    rf_pending_cnt #(.CNT_WID(CNT_WID)) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (inc_v[r]),
      .dec (dec_v[r]),
      .cnt (cnt_v[r]),
      .ovf (ovf_v[r])
    );
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WID-1:0] a;
    logic                a_vld, busy;
    logic [DATA_WID-1:0] dat;

    assign a     = rd_addr[i*ADDR_WID +: ADDR_WID];
    assign a_vld = ({1'b0, a} < NREG);

    always_comb begin
      dat  = '0;
      busy = 1'b0;
      if (a_vld) begin
        busy = (cnt_v[a] != '0);
        if ((BYPASS != 0) && we_m_vld && (destM == a))      dat = valM;
        else if ((BYPASS != 0) && we_e_vld && (destE == a)) dat = valE;
        else                                                 dat = data_q[a];
      end
    end

    assign rd_data[i*DATA_WID +: DATA_WID] = dat;
    assign rd_busy[i]                      = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Table-driven bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_mp;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  rd_addr;
  logic [127:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        we_E, we_M, sb_set;
  logic [3:0]  destE, destM, sb_addr;
  logic [63:0] valE, valM;
  logic        sb_err, sb_err_nb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  regfile_mp dut (
    .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we_E(we_E), .destE(destE), .valE(valE), .we_M(we_M), .destM(destM), .valM(valM),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_err(sb_err)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .we_E(we_E), .destE(destE), .valE(valE), .we_M(we_M), .destM(destM), .valM(valM),
    .sb_set(sb_set), .sb_addr(sb_addr), .sb_err(sb_err_nb)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  a0, a1;
    bit          we_e;  logic [3:0] de; logic [63:0] ve;
    bit          we_m;  logic [3:0] dm; logic [63:0] vm;
    bit          ss;    logic [3:0] sa;
    bit          chk;
    logic [63:0] e0, e1, n0, n1;
    logic [1:0]  eb;
    bit          ee;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   vec_no = 0;

  function automatic vec_t mk(bit rst, logic [3:0] a0, logic [3:0] a1,
                              bit we_e, logic [3:0] de, logic [63:0] ve,
                              bit we_m, logic [3:0] dm, logic [63:0] vm,
                              bit ss, logic [3:0] sa, bit chk,
                              logic [63:0] e0, logic [63:0] e1,
                              logic [63:0] n0, logic [63:0] n1,
                              logic [1:0] eb, bit ee);
    vec_t v;
    v.rst = rst; v.a0 = a0; v.a1 = a1;
    v.we_e = we_e; v.de = de; v.ve = ve;
    v.we_m = we_m; v.dm = dm; v.vm = vm;
    v.ss = ss; v.sa = sa; v.chk = chk;
    v.e0 = e0; v.e1 = e1; v.n0 = n0; v.n1 = n1; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  task automatic cmp(input int idx, input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %s: got %0h, want %0h", idx, nm, act, exp);
    end
  endtask

  // Drive one cycle, expect pushed on drive, popped and compared just before the edge.
  task automatic apply(input vec_t v);
    vec_t x;
    RST = v.rst; rd_addr = {v.a1, v.a0};
    we_E = v.we_e; destE = v.de; valE = v.ve;
    we_M = v.we_m; destM = v.dm; valM = v.vm;
    sb_set = v.ss; sb_addr = v.sa;
    sb_q.push_back(v);
    @(negedge CLK);
    x = sb_q.pop_front();
    if (x.chk) begin
      cmp(vec_no, "rd_data",    rd_data,    {x.e1, x.e0});
      cmp(vec_no, "rd_data_nb", rd_data_nb, {x.n1, x.n0});
      cmp(vec_no, "rd_busy",    {126'd0, rd_busy},    {126'd0, x.eb});
      cmp(vec_no, "rd_busy_nb", {126'd0, rd_busy_nb}, {126'd0, x.eb});
      cmp(vec_no, "sb_err",     {127'd0, sb_err},     {127'd0, x.ee});
      cmp(vec_no, "sb_err_nb",  {127'd0, sb_err_nb},  {127'd0, x.ee});
    end
    vec_no++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //               rst a0 a1  E  dE  vE      M  dM  vM      set sa  chk  e0      e1      n0      n1      busy err
    vecs.push_back(mk(1, 0, 0,  0, 0, 0,      0, 0, 0,      0, 0,  0,   0,      0,      0,      0,      0, 0));
    vecs.push_back(mk(0, 4, 0,  0, 0, 0,      0, 0, 0,      0, 0,  1,   64,     0,      64,     0,      0, 0));
    vecs.push_back(mk(0, 3, 3,  1, 3, 'h11,   1, 3, 'h22,   0, 0,  1,   'h22,   'h22,   0,      0,      0, 0));
    vecs.push_back(mk(0, 3, 3,  0, 0, 0,      0, 0, 0,      0, 0,  1,   'h22,   'h22,   'h22,   'h22,   0, 0));
    vecs.push_back(mk(0, 15, 3, 1, 15, 'hDEAD, 0, 0, 0,     0, 0,  1,   0,      'h22,   0,      'h22,   0, 0));
    vecs.push_back(mk(0, 14, 0, 0, 0, 0,      0, 0, 0,      0, 0,  1,   0,      0,      0,      0,      0, 0));
    vecs.push_back(mk(0, 5, 5,  0, 0, 0,      0, 0, 0,      1, 5,  1,   0,      0,      0,      0,      0, 0));
    vecs.push_back(mk(0, 5, 5,  0, 0, 0,      0, 0, 0,      1, 5,  1,   0,      0,      0,      0,      3, 0));
    vecs.push_back(mk(0, 5, 0,  1, 5, 'h55,   0, 0, 0,      0, 0,  1,   'h55,   0,      0,      0,      1, 0));
    vecs.push_back(mk(0, 5, 5,  0, 0, 0,      1, 5, 'h66,   0, 0,  1,   'h66,   'h66,   'h55,   'h55,   3, 0));
    vecs.push_back(mk(0, 5, 5,  0, 0, 0,      0, 0, 0,      0, 0,  1,   'h66,   'h66,   'h66,   'h66,   0, 0));
    vecs.push_back(mk(0, 2, 2,  0, 0, 0,      0, 0, 0,      1, 2,  1,   0,      0,      0,      0,      0, 0));
    vecs.push_back(mk(0, 2, 2,  0, 0, 0,      0, 0, 0,      1, 2,  1,   0,      0,      0,      0,      3, 0));
    vecs.push_back(mk(0, 2, 2,  0, 0, 0,      0, 0, 0,      1, 2,  1,   0,      0,      0,      0,      3, 0));
    vecs.push_back(mk(0, 2, 2,  0, 0, 0,      0, 0, 0,      1, 2,  1,   0,      0,      0,      0,      3, 0));
    vecs.push_back(mk(0, 2, 2,  1, 2, 'h77,   0, 0, 0,      0, 0,  1,   'h77,   'h77,   0,      0,      3, 1));
    vecs.push_back(mk(1, 2, 2,  0, 0, 0,      1, 6, 'h99,   1, 6,  1,   'h77,   'h77,   'h77,   'h77,   3, 1));
    vecs.push_back(mk(0, 2, 6,  0, 0, 0,      0, 0, 0,      0, 0,  1,   0,      0,      0,      0,      0, 0));
    vecs.push_back(mk(0, 7, 4,  0, 0, 0,      0, 0, 0,      1, 7,  1,   0,      64,     0,      64,     0, 0));
    vecs.push_back(mk(0, 7, 7,  1, 7, 'h7,    0, 0, 0,      1, 7,  1,   'h7,    'h7,    0,      0,      3, 0));
    vecs.push_back(mk(0, 7, 7,  0, 0, 0,      0, 0, 0,      0, 0,  1,   'h7,    'h7,    'h7,    'h7,    3, 0));
    vecs.push_back(mk(0, 7, 7,  0, 0, 0,      1, 7, 'h8,    0, 0,  1,   'h8,    'h8,    'h7,    'h7,    3, 0));
    vecs.push_back(mk(0, 7, 7,  1, 7, 'h9,    1, 7, 'hA,    0, 0,  1,   'hA,    'hA,    'h8,    'h8,    0, 0));
    vecs.push_back(mk(0, 7, 4,  0, 0, 0,      0, 0, 0,      1, 15, 1,   'hA,    64,     'hA,    64,     0, 0));
    vecs.push_back(mk(0, 15, 7, 0, 0, 0,      0, 0, 0,      0, 0,  1,   0,      'hA,    0,      'hA,    0, 0));

    foreach (vecs[k]) apply(vecs[k]);

    // Two in-flight results on reg 9 retired by E and M in the same edge.
    apply(mk(0, 9, 9, 0, 0, 0,     0, 0, 0,     1, 9, 1, 0,     0,     0,     0,     0, 0));
    apply(mk(0, 9, 9, 0, 0, 0,     0, 0, 0,     1, 9, 1, 0,     0,     0,     0,     3, 0));
    apply(mk(0, 9, 4, 1, 9, 'h1,   1, 9, 'h2,   0, 0, 1, 'h2,   64,    0,     64,    1, 0));
    apply(mk(0, 9, 9, 0, 0, 0,     0, 0, 0,     0, 0, 1, 'h2,   'h2,   'h2,   'h2,   0, 0));

    // Stack pointer overwrite, then restore to its preset through a reset.
    apply(mk(0, 4, 4, 1, 4, 'h123, 0, 0, 0,     0, 0, 1, 'h123, 'h123, 64,    64,    0, 0));
    apply(mk(0, 4, 9, 0, 0, 0,     0, 0, 0,     0, 0, 1, 'h123, 'h2,   'h123, 'h2,   0, 0));
    apply(mk(1, 4, 9, 0, 0, 0,     0, 0, 0,     0, 0, 0, 0,     0,     0,     0,     0, 0));
    apply(mk(0, 4, 9, 0, 0, 0,     0, 0, 0,     0, 0, 1, 64,    0,     64,    0,     0, 0));

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
